// File: rtl/sampler.sv
// Rate-reduction stage: passes one valid sample every (effDiv+1) accepted inputs,
// zeroing disabled 8-channel groups on the registered output.
module sampler #(
    parameter int unsigned DIV_WIDTH  = 24,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   dataInput,
    input  logic                    validIn,
    input  logic                    enable,
    input  logic                    demuxMode,
    input  logic [DATA_WIDTH/8-1:0] disabledGroups,
    input  logic                    wrDivider,
    input  logic [DIV_WIDTH-1:0]    configData,
    output logic [DATA_WIDTH-1:0]   dataOutput,
    output logic                    validOut,
    output logic [DIV_WIDTH-1:0]    divider
);

    localparam int unsigned NUM_GROUPS = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [DIV_WIDTH-1:0]  divider_q, divider_d;
    logic [DIV_WIDTH-1:0]  counter_q, counter_d;
    logic [DIV_WIDTH-1:0]  eff_div;
    logic [DIV_WIDTH-1:0]  cfg_eff_div;
    logic [DATA_WIDTH-1:0] masked;

    // In demux mode each word carries two time slots, so the count is halved.
    always_comb begin
        eff_div     = demuxMode ? (divider_q >> 1) : divider_q;
        cfg_eff_div = demuxMode ? (configData >> 1) : configData;
        masked      = dataInput;
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            if (disabledGroups[g]) begin
                masked[g*8 +: 8] = '0;
            end
        end
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = 1'b0;
        divider_d = divider_q;
        counter_d = counter_q;
        if (wrDivider) begin
            divider_d = configData;
            counter_d = cfg_eff_div;
        end else if (!enable) begin
            counter_d = eff_div;
        end else if (validIn) begin
            if (counter_q == '0) begin
                data_d    = masked;
                valid_d   = 1'b1;
                counter_d = eff_div;
            end else begin
                counter_d = counter_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            divider_q <= '0;
            counter_q <= '0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            divider_q <= divider_d;
            counter_q <= counter_d;
        end
    end

    assign dataOutput = data_q;
    assign validOut   = valid_q;
    assign divider    = divider_q;

endmodule

// File: tb/tb_sampler.sv
// Directed bench for sampler: pass-through, decimation, demux halving,
// group masking, write/enable collisions and asynchronous reset.
module tb_sampler;

    logic        clock;
    logic        reset_n;
    logic [31:0] dataInput;
    logic        validIn;
    logic        enable;
    logic        demuxMode;
    logic [3:0]  disabledGroups;
    logic        wrDivider;
    logic [23:0] configData;
    logic [31:0] dataOutput;
    logic        validOut;
    logic [23:0] divider;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_out = '0;

    sampler #(.DIV_WIDTH(24), .DATA_WIDTH(32)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .dataInput(dataInput),
        .validIn(validIn),
        .enable(enable),
        .demuxMode(demuxMode),
        .disabledGroups(disabledGroups),
        .wrDivider(wrDivider),
        .configData(configData),
        .dataOutput(dataOutput),
        .validOut(validOut),
        .divider(divider)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_div(input logic [23:0] val);
        wrDivider  = 1'b1;
        configData = val;
        validIn    = 1'b0;
        step();
        wrDivider  = 1'b0;
    endtask

    // Drive n valid inputs with data base..base+n-1; a pulse is expected on
    // every input whose index mod period equals period-1.
    task automatic run_stream(input string name, input int n, input int period, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            validIn   = 1'b1;
            dataInput = base + i;
            step();
            checks++;
            if (validOut !== ((i % period) == period - 1)) begin
                errors++;
                $display("FAIL %s valid[%0d]: got %b expected %b", name, i, validOut, (i % period) == period - 1);
            end
            if ((i % period) == period - 1) last_out = base + i;
            checks++;
            if (dataOutput !== last_out) begin
                errors++;
                $display("FAIL %s data[%0d]: got %h expected %h", name, i, dataOutput, last_out);
            end
        end
        validIn = 1'b0;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        dataInput      = 32'hDEAD_BEEF;
        validIn        = 1'b1;
        enable         = 1'b1;
        demuxMode      = 1'b0;
        disabledGroups = '0;
        wrDivider      = 1'b0;
        configData     = 24'd7;
        repeat (3) step();
        checks++;
        if (validOut !== 1'b0 || dataOutput !== 32'h0 || divider !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h div=%h expected v=0 d=0 div=0", validOut, dataOutput, divider);
        end
        reset_n = 1'b1;
        validIn = 1'b0;
    endtask

    task automatic test_passthrough();
        enable = 1'b1;
        run_stream("passthru", 5, 1, 32'h0);
    endtask

    task automatic test_div4();
        write_div(24'd3);
        checks++;
        if (divider !== 24'd3 || validOut !== 1'b0) begin
            errors++;
            $display("FAIL div4_write: got div=%0d v=%b expected div=3 v=0", divider, validOut);
        end
        run_stream("div4", 12, 4, 32'h0);
    endtask

    task automatic test_demux();
        demuxMode = 1'b1;
        write_div(24'd5);
        run_stream("demux1", 9, 3, 32'h100);
        demuxMode = 1'b0;
        write_div(24'd5);
        run_stream("demux0", 12, 6, 32'h200);
    endtask

    task automatic test_mask();
        write_div(24'd0);
        disabledGroups = 4'b1010;
        validIn        = 1'b1;
        dataInput      = 32'hAABB_CCDD;
        step();
        checks++;
        if (validOut !== 1'b1 || dataOutput !== 32'h00BB_00DD) begin
            errors++;
            $display("FAIL mask_1010: got v=%b d=%h expected v=1 d=00bb00dd", validOut, dataOutput);
        end
        disabledGroups = 4'b0101;
        dataInput      = 32'h1122_3344;
        step();
        checks++;
        if (validOut !== 1'b1 || dataOutput !== 32'h1100_3300) begin
            errors++;
            $display("FAIL mask_0101: got v=%b d=%h expected v=1 d=11003300", validOut, dataOutput);
        end
        last_out       = 32'h1100_3300;
        disabledGroups = '0;
        validIn        = 1'b0;
    endtask

    task automatic test_collision();
        write_div(24'd3);
        run_stream("coll_pre", 2, 4, 32'h300);
        wrDivider  = 1'b1;
        configData = 24'd2;
        validIn    = 1'b1;
        dataInput  = 32'h55;
        step();
        wrDivider  = 1'b0;
        checks++;
        if (validOut !== 1'b0 || divider !== 24'd2) begin
            errors++;
            $display("FAIL coll_write: got v=%b div=%0d expected v=0 div=2", validOut, divider);
        end
        run_stream("coll_after", 3, 3, 32'h400);
        run_stream("en_pre", 1, 3, 32'h500);
        enable  = 1'b0;
        validIn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dataInput = 32'h600 + i;
            step();
            checks++;
            if (validOut !== 1'b0 || dataOutput !== last_out) begin
                errors++;
                $display("FAIL en_low[%0d]: got v=%b d=%h expected v=0 d=%h", i, validOut, dataOutput, last_out);
            end
        end
        enable = 1'b1;
        run_stream("en_restart", 6, 3, 32'h700);
    endtask

    task automatic test_async_reset();
        write_div(24'd9);
        run_stream("rst_pre", 4, 10, 32'h800);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (validOut !== 1'b0 || dataOutput !== 32'h0 || divider !== 24'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h div=%h expected v=0 d=0 div=0", validOut, dataOutput, divider);
        end
        reset_n  = 1'b1;
        last_out = '0;
        run_stream("rst_post", 3, 1, 32'h900);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_div4();
        test_demux();
        test_mask();
        test_collision();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
